// File: rtl/sigmoid_grad_if.sv
// sigmoid_grad_if: input/output valid-ready channels of the sigmoid backward unit.
// Values are signed fixed point Q(QN).(QM).
interface sigmoid_grad_if #(
   parameter int QN = 6,
   parameter int QM = 11
) ();
   localparam int BITWIDTH = QN + QM + 1;

   logic                       in_valid;
   logic                       in_ready;
   logic signed [BITWIDTH-1:0] y_in;
   logic signed [BITWIDTH-1:0] grad_in;
   logic                       out_valid;
   logic                       out_ready;
   logic signed [BITWIDTH-1:0] delta_out;

   // producer of y/grad and consumer of delta
   modport master (
      output in_valid, y_in, grad_in, out_ready,
      input  in_ready, out_valid, delta_out
   );

   // the sigmoid_grad block itself
   modport slave (
      input  in_valid, y_in, grad_in, out_ready,
      output in_ready, out_valid, delta_out
   );
endinterface

// File: rtl/sigmoid_grad.sv
// sigmoid_grad: delta = g * y * (1 - y) in signed Q(QN).(QM).
// One shared multiplier, two multiply cycles (MUL1: y*(1-y), MUL2: t*g).
// Optional macro SIGMOID_GRAD_ROUND_EN: round-half-up on both shifts
// instead of floor. Latency/handshake identical either way.
module sigmoid_grad #(
   parameter int QN = 6,
   parameter int QM = 11
) (
   input  logic          clk,
   input  logic          reset,
   sigmoid_grad_if.slave bus,
   output logic          busy
);
   localparam int BITWIDTH = QN + QM + 1;
   localparam int PW       = 2 * BITWIDTH;
   localparam logic signed [BITWIDTH-1:0] ONE = BITWIDTH'(1 << QM);
`ifdef SIGMOID_GRAD_ROUND_EN
   localparam logic signed [PW-1:0] RND = PW'(1 << (QM - 1));
`else
   localparam logic signed [PW-1:0] RND = '0;
`endif

   typedef enum logic [1:0] {IDLE, MUL1, MUL2, DONE} state_t;

   state_t                     state, state_nxt;
   logic                       in_ready_c;
   logic                       accept;
   logic signed [BITWIDTH-1:0] y_clamp;
   logic signed [BITWIDTH-1:0] y_c, g_r, t_r, delta_r;
   logic signed [BITWIDTH-1:0] mul_a, mul_b, mul_res;
   logic signed [PW-1:0]       prod;

   assign accept        = bus.in_valid & in_ready_c;
   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = (state == DONE);
   assign bus.delta_out = delta_r;
   assign busy          = (state != IDLE);

   // clamp y into [0, ONE] before capture so 1-y never goes negative
   always_comb begin
      y_clamp = bus.y_in;
      if (bus.y_in < 0)
         y_clamp = '0;
      else if (bus.y_in > ONE)
         y_clamp = ONE;
   end

   // shared multiplier operand mux: (y, 1-y) except in MUL2 where (t, g)
   always_comb begin
      mul_a = y_c;
      mul_b = ONE - y_c;
      if (state == MUL2) begin
         mul_a = t_r;
         mul_b = g_r;
      end
   end

   // full-width signed product, then arithmetic shift back to Q format;
   // t <= 512 keeps every result inside BITWIDTH so the truncation is exact
   assign prod    = PW'(mul_a) * PW'(mul_b);
   assign mul_res = BITWIDTH'((prod + RND) >>> QM);

   // next-state and input acceptance; DONE can hand off straight into MUL1
   always_comb begin
      state_nxt  = state;
      in_ready_c = 1'b0;
      case (state)
         IDLE: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) state_nxt = MUL1;
         end
         MUL1: state_nxt = MUL2;
         MUL2: state_nxt = DONE;
         DONE: begin
            in_ready_c = bus.out_ready;
            if (bus.out_ready) state_nxt = bus.in_valid ? MUL1 : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // operand capture and per-stage result registers; delta held until replaced
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         y_c     <= '0;
         g_r     <= '0;
         t_r     <= '0;
         delta_r <= '0;
      end else begin
         if (accept) begin
            y_c <= y_clamp;
            g_r <= bus.grad_in;
         end
         if (state == MUL1) t_r     <= mul_res;
         if (state == MUL2) delta_r <= mul_res;
      end
   end
endmodule

// File: tb/tb_sigmoid_grad.sv
// tb_sigmoid_grad: directed + streaming stimulus, scoreboard queue checked by
// an independent monitor (value and 2-edge latency per result).
module tb_sigmoid_grad;
   localparam int QN = 6;
   localparam int QM = 11;
   localparam int BW = QN + QM + 1;
`ifdef SIGMOID_GRAD_ROUND_EN
   localparam longint R = 1024;
`else
   localparam longint R = 0;
`endif

   typedef struct {
      int exp;
      int acc;
   } sb_t;

   logic clk, reset, busy;
   int   cyc, checks, errors;
   bit   pres;
   sb_t  sb[$];

   sigmoid_grad_if #(.QN(QN), .QM(QM)) bus ();
   sigmoid_grad #(.QN(QN), .QM(QM)) dut (.clk(clk), .reset(reset), .bus(bus), .busy(busy));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int model(input int y, input int g);
      longint yc, t, d;
      yc = (y < 0) ? 0 : ((y > 2048) ? 2048 : y);
      t  = (yc * (2048 - yc) + R) >>> 11;
      d  = (t * g + R) >>> 11;
      return int'(d);
   endfunction

   // present one vector and wait (bounded) until it is accepted
   task automatic send(input int y, input int g, input int exp, output int acc);
      int n = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.y_in     = BW'(y);
      bus.grad_in  = BW'(g);
      #1;
      while (!bus.in_ready && n < 50) begin
         @(negedge clk); #1; n++;
      end
      acc = -1;
      if (!bus.in_ready) begin
         chk("accept_timeout", 0, 1);
      end else begin
         acc = cyc + 1;
         sb.push_back('{exp, acc});
         @(posedge clk);
      end
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // monitor: latency on first presentation, value on handshake
   initial begin
      pres = 1'b0;
      forever begin
         @(negedge clk); #2;
         if (bus.out_valid) begin
            if (!pres) begin
               pres = 1'b1;
               if (sb.size() == 0) chk("unexpected_output", 1, 0);
               else                chk("latency", cyc, sb[0].acc + 2);
            end
            if (bus.out_ready) begin
               if (sb.size() == 0) chk("unexpected_output", 1, 0);
               else begin
                  sb_t e;
                  e = sb.pop_front();
                  chk("delta", int'($signed(bus.delta_out)), e.exp);
               end
               pres = 1'b0;
            end
         end else begin
            pres = 1'b0;
         end
      end
   end

   initial begin
      int acc, prev, n;
      int ys[6];
      int es[6];
      cyc = 0; checks = 0; errors = 0;
      reset = 1'b0;
      bus.in_valid = 1'b0; bus.y_in = '0; bus.grad_in = '0; bus.out_ready = 1'b1;
      #12;
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_delta", int'(bus.delta_out), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_in_ready", int'(bus.in_ready), 1);
      @(negedge clk); reset = 1'b1;

      // directed values
      send(1024, 2048, 512, acc);
      send(1024, -2048, -512, acc);
      ys = '{512, 0, 2048, -100, 3000, 1};
`ifdef SIGMOID_GRAD_ROUND_EN
      es = '{-192, 0, 0, 0, 0, 1};
`else
      es = '{-192, 0, 0, 0, 0, 0};
`endif
      send(ys[0], -1024, es[0], acc);
      for (int i = 1; i < 6; i++) send(ys[i], 2048, es[i], acc);
      idle(5);

      // backpressure: held output, junk input ignored, then simultaneous handoff
      bus.out_ready = 1'b0;
      send(512, -1024, -192, acc);
      @(negedge clk);
      bus.in_valid = 1'b1; bus.y_in = BW'(100); bus.grad_in = BW'(5000);
      #1;
      n = 0;
      while (!bus.out_valid && n < 10) begin
         @(negedge clk); #1; n++;
      end
      chk("bp_out_valid", int'(bus.out_valid), 1);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) begin @(negedge clk); #1; end
         chk("bp_hold_delta", int'($signed(bus.delta_out)), -192);
         chk("bp_in_ready", int'(bus.in_ready), 0);
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.y_in = BW'(1024); bus.grad_in = BW'(2048);
      #1;
      chk("bp_handoff_ready", int'(bus.in_ready), 1);
      sb.push_back('{512, cyc + 1});
      @(posedge clk);
      idle(5);

      // asynchronous reset during MUL1 (delta register currently holds 512)
      @(negedge clk);
      bus.in_valid = 1'b1; bus.y_in = BW'(512); bus.grad_in = BW'(-1024);
      #1;
      chk("rst_mid_accept", int'(bus.in_ready), 1);
      @(posedge clk); #2;
      chk("rst_mid_busy_before", int'(busy), 1);
      reset = 1'b0;
      #1;
      chk("rst_mid_out_valid", int'(bus.out_valid), 0);
      chk("rst_mid_delta", int'(bus.delta_out), 0);
      chk("rst_mid_busy", int'(busy), 0);
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      send(512, -1024, -192, acc);
      idle(5);

      // streaming with out_ready high: one result every 3 cycles
      prev = -1;
      for (int i = 0; i < 16; i++) begin
         int y, g;
         y = int'($urandom_range(2500, 0)) - 200;
         g = int'($urandom_range(262143, 0)) - 131072;
         send(y, g, model(y, g), acc);
         if (prev >= 0 && acc >= 0) chk("stream_interval", acc - prev, 3);
         prev = acc;
      end
      idle(1);

      n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(negedge clk); n++;
      end
      chk("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
